adc_scan_scheduler: RTL and testbench
=====================================

Name: adc_scan_scheduler

Overview:
Sequences the 8-channel AD7928 serial front end for the oscilloscope capture path.
- Runs power-up dummy conversions.
- Issues conversions at a programmed sample period, round-robin over the enabled channels.
- Builds the 16-bit ADC control word.
- Resolves the ADC's one-frame result pipeline and emits tagged samples.
- Sits between the capture/trigger logic (downstream) and the SPI frame engine (upstream handshake).

Parameters:
CH_NUM, 8, number of ADC channels (address width 3)
DIV_W, 16, width of the sample-period counter
MIN_PERIOD, 40, minimum clk cycles between conversion starts (frame length 38 + margin)
DUMMY_CONV, 2, dummy conversions after reset

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
en  in  1  scan enable
ch_mask  in  8  channel enable mask, bit i = channel i
period  in  DIV_W  clk cycles between conversion starts
cfg_range  in  1  RANGE bit for control word
cfg_coding  in  1  CODING bit for control word
err_clr  in  1  single-cycle clear of sticky error flags
conv_req  out  1  conversion request to frame engine
conv_word  out  16  control word for the requested frame, stable while conv_req=1
conv_ack  in  1  frame engine accepted request (1-cycle pulse)
conv_done  in  1  frame finished (1-cycle pulse)
conv_data  in  16  raw frame: [15]=0, [14:12]=addr, [11:0]=data; valid with conv_done
smp_vld  out  1  sample valid pulse
smp_ch  out  3  sample channel
smp_data  out  12  sample value
ovr  out  1  sticky: sample tick missed
addr_err  out  1  sticky: returned address mismatch
busy  out  1  FSM not in IDLE

Behaviour:
- Reset (async, rst=1): all outputs 0, conv_word=16'h0000, FSM=DUMMY_REQ pending, dummy count=0, prev_valid=0, channel pointer=7 (so first pick is lowest enabled channel ≥0).
- Effective period: eff = max(period, MIN_PERIOD). Counter runs only while en=1 and counts 0..eff-1; tick when it wraps. Counter reloads to 0 on en rising edge.
- FSM states:
  - IDLE: busy=0; en=1 → DUMMY if dummies remain, else WAIT_TICK.
  - DUMMY: conv_req=1, conv_word=16'hFFFF. After conv_ack, wait for conv_done. Increment count; at DUMMY_CONV go to WAIT_TICK, else repeat. Ticks are ignored here.
  - WAIT_TICK: on tick with ch_mask≠0: pick the next enabled channel after the pointer (wrap 7→0), update the pointer, go to REQ. With ch_mask=0, stay and issue nothing. en=0 → IDLE.
  - REQ: conv_req=1, conv_word={1,0,0,addr[2:0],2'b11,0,0,cfg_range,cfg_coding,4'b0000}. conv_req drops the cycle after conv_ack. Go to WAIT_DONE.
  - WAIT_DONE: on conv_done: process result; set prev_addr=addr, prev_valid=1; go to WAIT_TICK, or IDLE if en=0.
- en deasserted in REQ/WAIT_DONE: the in-flight frame completes before IDLE. On re-entry from IDLE, prev_valid=0.
- Tick arriving in REQ/WAIT_DONE: dropped and ovr←1. Simultaneous err_clr and set: set wins.
- Result processing on conv_done in WAIT_DONE:
  - prev_valid=0 → discard.
  - conv_data[15]=0 and conv_data[14:12]=prev_addr → next cycle smp_vld=1, smp_ch=prev_addr, smp_data=conv_data[11:0]. smp_ch/smp_data hold until the next sample.
  - Otherwise → addr_err←1, no smp_vld.
- Dummy frame results are always discarded.
- ch_mask and cfg_* are sampled only at channel pick; changes never alter an in-flight conv_word.
- conv_ack without conv_req, or conv_done outside DUMMY/WAIT_DONE: ignored.
- Latency: conv_done → smp_vld = 1 cycle.

Decomposition:
- Package adc_pkg holds:
  - control word field constants: WRITE, SEQ, PM=2'b11, SHADOW, DUMMY_WORD=16'hFFFF
  - CH_NUM, ADDR_W=3, FRAME_LEN=38, MIN_PERIOD default
  - FSM state enum
- Sub-module adc_rr_pick: combinational next-enabled-channel picker taking (mask, pointer) and returning (next, found).

Test Plan:
1. Reset release, en=1, mask=8'hFF, period=40 → two frames with conv_word=16'hFFFF, then conv_words for addr 0,1,2… spaced 40 cycles; first real result discarded; smp_vld with smp_ch=0 one cycle after the second real conv_done.
2. mask=8'b0010_0100 → conv_word addr sequence 2,5,2,5; smp_ch sequence 2,5 with one-frame lag.
3. Frame-engine model delays conv_done 60 cycles, period=40 → ovr=1 and stays set; err_clr pulse → ovr=0.
4. Model returns addr 3 when 2 expected → addr_err=1, no smp_vld for that frame; next correct frame emits normally.
5. period=5 → conv_req starts exactly MIN_PERIOD=40 cycles apart; mask=0 → no conv_req for 500 cycles.
6. rst asserted mid WAIT_DONE → all outputs 0 asynchronously; after release, two dummy frames replay before the first addressed request.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared constants, FSM encoding and control-word builder for the AD7928 scan scheduler.
package adc_pkg;

    localparam int ADDR_W         = 3;
    localparam int CH_NUM_DEF     = 8;
    localparam int FRAME_LEN      = 38;
    localparam int MIN_PERIOD_DEF = FRAME_LEN + 2;
    localparam int DUMMY_CONV_DEF = 2;
    localparam int DIV_W_DEF      = 16;

    localparam logic        WRITE      = 1'b1;
    localparam logic        SEQ        = 1'b0;
    localparam logic [1:0]  PM         = 2'b11;
    localparam logic        SHADOW     = 1'b0;
    localparam logic [15:0] DUMMY_WORD = 16'hFFFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DUMMY_REQ,
        S_DUMMY_WAIT,
        S_WAIT_TICK,
        S_REQ,
        S_WAIT_DONE
    } state_e;

    // Bit order: WRITE SEQ x ADD[2:0] PM[1:0] SHADOW x RANGE CODING 0000
    function automatic logic [15:0] ctrl_word(input logic [ADDR_W-1:0] addr,
                                              input logic rng, input logic cod);
        return {WRITE, SEQ, 1'b0, addr, PM, SHADOW, 1'b0, rng, cod, 4'b0000};
    endfunction

endpackage

// File: rtl/adc_rr_pick.sv
// Combinational round-robin picker: first enabled channel strictly after ptr_i, wrapping.
module adc_rr_pick
    import adc_pkg::*;
#(
    parameter int N  = CH_NUM_DEF,
    parameter int AW = ADDR_W
) (
    input  logic [N-1:0]  mask_i,
    input  logic [AW-1:0] ptr_i,
    output logic [AW-1:0] next_o,
    output logic          found_o
);

    logic [AW-1:0] cand [N];
    logic [N-1:0]  hit;

    // Candidate gi is ptr+gi+1; the last candidate wraps back onto ptr itself.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_cand
            assign cand[gi] = ptr_i + AW'(gi + 1);
            assign hit[gi]  = mask_i[cand[gi]];
        end
    endgenerate

    always_comb begin
        next_o  = ptr_i;
        found_o = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (hit[i]) begin
                next_o  = cand[i];
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adc_scan_scheduler.sv
// AD7928 scan scheduler: dummy conversions, periodic round-robin requests and
// resolution of the ADC's one-frame result lag into tagged samples.
module adc_scan_scheduler
    import adc_pkg::*;
#(
    parameter int CH_NUM     = CH_NUM_DEF,
    parameter int DIV_W      = DIV_W_DEF,
    parameter int MIN_PERIOD = MIN_PERIOD_DEF,
    parameter int DUMMY_CONV = DUMMY_CONV_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [CH_NUM-1:0] ch_mask,
    input  logic [DIV_W-1:0]  period,
    input  logic              cfg_range,
    input  logic              cfg_coding,
    input  logic              err_clr,
    output logic              conv_req,
    output logic [15:0]       conv_word,
    input  logic              conv_ack,
    input  logic              conv_done,
    input  logic [15:0]       conv_data,
    output logic              smp_vld,
    output logic [ADDR_W-1:0] smp_ch,
    output logic [11:0]       smp_data,
    output logic              ovr,
    output logic              addr_err,
    output logic              busy
);

    localparam int DW = $clog2(DUMMY_CONV + 2);

    state_e             state_q, state_d;
    logic [DIV_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  ptr_q, ptr_d;
    logic [ADDR_W-1:0]  prev_addr_q, prev_addr_d;
    logic               prev_valid_q, prev_valid_d;
    logic [DW-1:0]      dummy_cnt_q, dummy_cnt_d;
    logic [15:0]        word_q, word_d;
    logic               smp_vld_q, smp_vld_d;
    logic [ADDR_W-1:0]  smp_ch_q, smp_ch_d;
    logic [11:0]        smp_data_q, smp_data_d;
    logic               ovr_q, ovr_d;
    logic               addr_err_q, addr_err_d;

    logic [DIV_W-1:0]   eff_period;
    logic               tick;
    logic [ADDR_W-1:0]  pick_next;
    logic               pick_found;

    // Counter is held at 0 while disabled, so an en rising edge restarts the period.
    assign eff_period = (period < DIV_W'(MIN_PERIOD)) ? DIV_W'(MIN_PERIOD) : period;
    assign tick       = en && (cnt_q >= eff_period - 1'b1);
    assign cnt_d      = (!en || tick) ? '0 : cnt_q + 1'b1;

    adc_rr_pick #(.N(CH_NUM), .AW(ADDR_W)) u_pick (
        .mask_i  (ch_mask),
        .ptr_i   (ptr_q),
        .next_o  (pick_next),
        .found_o (pick_found)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            ptr_q        <= ADDR_W'(CH_NUM - 1);
            prev_addr_q  <= '0;
            prev_valid_q <= 1'b0;
            dummy_cnt_q  <= '0;
            word_q       <= '0;
            smp_vld_q    <= 1'b0;
            smp_ch_q     <= '0;
            smp_data_q   <= '0;
            ovr_q        <= 1'b0;
            addr_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ptr_q        <= ptr_d;
            prev_addr_q  <= prev_addr_d;
            prev_valid_q <= prev_valid_d;
            dummy_cnt_q  <= dummy_cnt_d;
            word_q       <= word_d;
            smp_vld_q    <= smp_vld_d;
            smp_ch_q     <= smp_ch_d;
            smp_data_q   <= smp_data_d;
            ovr_q        <= ovr_d;
            addr_err_q   <= addr_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        prev_addr_d  = prev_addr_q;
        prev_valid_d = prev_valid_q;
        dummy_cnt_d  = dummy_cnt_q;
        word_d       = word_q;
        smp_vld_d    = 1'b0;
        smp_ch_d     = smp_ch_q;
        smp_data_d   = smp_data_q;
        ovr_d        = ovr_q;
        addr_err_d   = addr_err_q;
        // Clear is applied first so a same-cycle set below takes priority.
        if (err_clr) begin
            ovr_d      = 1'b0;
            addr_err_d = 1'b0;
        end
        case (state_q)
            S_IDLE: begin
                prev_valid_d = 1'b0;
                if (en) begin
                    if (dummy_cnt_q < DW'(DUMMY_CONV)) begin
                        state_d = S_DUMMY_REQ;
                        word_d  = DUMMY_WORD;
                    end else begin
                        state_d = S_WAIT_TICK;
                    end
                end
            end
            S_DUMMY_REQ: if (conv_ack) state_d = S_DUMMY_WAIT;
            S_DUMMY_WAIT: begin
                if (conv_done) begin
                    dummy_cnt_d = dummy_cnt_q + 1'b1;
                    if (dummy_cnt_q == DW'(DUMMY_CONV - 1)) begin
                        state_d = S_WAIT_TICK;
                    end else begin
                        state_d = S_DUMMY_REQ;
                        word_d  = DUMMY_WORD;
                    end
                end
            end
            S_WAIT_TICK: begin
                if (!en) begin
                    state_d = S_IDLE;
                end else if (tick && pick_found) begin
                    ptr_d   = pick_next;
                    word_d  = ctrl_word(pick_next, cfg_range, cfg_coding);
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (tick) ovr_d = 1'b1;
                if (conv_ack) state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (tick) ovr_d = 1'b1;
                if (conv_done) begin
                    // The returned frame carries the conversion requested one frame earlier.
                    if (prev_valid_q) begin
                        if (!conv_data[15] && conv_data[14:12] == prev_addr_q) begin
                            smp_vld_d  = 1'b1;
                            smp_ch_d   = prev_addr_q;
                            smp_data_d = conv_data[11:0];
                        end else begin
                            addr_err_d = 1'b1;
                        end
                    end
                    prev_addr_d  = ptr_q;
                    prev_valid_d = 1'b1;
                    state_d      = en ? S_WAIT_TICK : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        conv_req  = (state_q == S_DUMMY_REQ) || (state_q == S_REQ);
        busy      = (state_q != S_IDLE);
        conv_word = word_q;
        smp_vld   = smp_vld_q;
        smp_ch    = smp_ch_q;
        smp_data  = smp_data_q;
        ovr       = ovr_q;
        addr_err  = addr_err_q;
    end

endmodule

// File: tb/tb_adc_scan_scheduler.sv
// Directed bench: table of scan steps plus hand sequences for overrun, period clamp,
// idle re-entry and asynchronous reset mid-frame.
module tb_adc_scan_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [7:0]  ch_mask = 8'hFF;
    logic [15:0] period = 16'd40;
    logic        cfg_range = 1'b0;
    logic        cfg_coding = 1'b0;
    logic        err_clr = 1'b0;
    logic        conv_req;
    logic [15:0] conv_word;
    logic        conv_ack = 1'b0;
    logic        conv_done = 1'b0;
    logic [15:0] conv_data = 16'h0000;
    logic        smp_vld;
    logic [2:0]  smp_ch;
    logic [11:0] smp_data;
    logic        ovr;
    logic        addr_err;
    logic        busy;

    adc_scan_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .ch_mask    (ch_mask),
        .period     (period),
        .cfg_range  (cfg_range),
        .cfg_coding (cfg_coding),
        .err_clr    (err_clr),
        .conv_req   (conv_req),
        .conv_word  (conv_word),
        .conv_ack   (conv_ack),
        .conv_done  (conv_done),
        .conv_data  (conv_data),
        .smp_vld    (smp_vld),
        .smp_ch     (smp_ch),
        .smp_data   (smp_data),
        .ovr        (ovr),
        .addr_err   (addr_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int cmp_n = 0;
    int fail_n = 0;
    logic [2:0] eng_prev = 3'd0;

    typedef struct {
        logic [7:0]  mask;
        logic        rng;
        logic        cod;
        logic        corrupt;
        logic [15:0] word;
        logic        vld;
        logic [2:0]  ch;
        logic [11:0] data;
        logic        aerr;
    } vec_t;

    vec_t vt[8];

    function automatic logic [11:0] data_of(input logic [2:0] a);
        return 12'h5A0 + 12'(a);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        cmp_n++;
        if (act !== exp) begin
            fail_n++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end else begin
            $display("ok   %s: %0h (cycle %0d)", nm, act, cyc);
        end
    endtask

    // Frame engine: accept request, return result for previously addressed channel.
    task automatic serve(input int dly, input logic corrupt,
                         output logic [15:0] word, output int req_cyc);
        int t;
        t = 0;
        while (conv_req !== 1'b1 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (conv_req !== 1'b1) begin
            cmp_n++;
            fail_n++;
            $display("FAIL req_timeout: got conv_req=0 expected 1 within 3000 cycles");
            word = 16'h0000;
            req_cyc = 0;
            return;
        end
        word = conv_word;
        req_cyc = cyc;
        conv_ack = 1'b1;
        @(negedge clk);
        conv_ack = 1'b0;
        chk("req_drop_after_ack", 32'(conv_req), 32'd0);
        repeat (dly - 1) @(negedge clk);
        conv_data = {1'b0, corrupt ? (eng_prev ^ 3'b110) : eng_prev, data_of(eng_prev)};
        conv_done = 1'b1;
        @(negedge clk);
        conv_done = 1'b0;
        conv_data = 16'h0000;
        eng_prev = word[12:10];
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] w;
        int rc, prev_rc, t, nreq;

        vt[0] = '{8'hFF, 1'b0, 1'b0, 1'b0, 16'h8300, 1'b0, 3'd0, 12'h000, 1'b0};
        vt[1] = '{8'hFF, 1'b0, 1'b0, 1'b0, 16'h8700, 1'b1, 3'd0, 12'h5A0, 1'b0};
        vt[2] = '{8'hFF, 1'b0, 1'b0, 1'b0, 16'h8B00, 1'b1, 3'd1, 12'h5A1, 1'b0};
        vt[3] = '{8'h24, 1'b0, 1'b0, 1'b0, 16'h9700, 1'b1, 3'd2, 12'h5A2, 1'b0};
        vt[4] = '{8'h24, 1'b0, 1'b0, 1'b0, 16'h8B00, 1'b1, 3'd5, 12'h5A5, 1'b0};
        vt[5] = '{8'h24, 1'b1, 1'b0, 1'b0, 16'h9720, 1'b1, 3'd2, 12'h5A2, 1'b0};
        vt[6] = '{8'h24, 1'b0, 1'b1, 1'b1, 16'h8B10, 1'b0, 3'd2, 12'h5A2, 1'b1};
        vt[7] = '{8'h24, 1'b0, 1'b0, 1'b0, 16'h9700, 1'b1, 3'd2, 12'h5A2, 1'b1};

        // Reset state
        #12;
        chk("rst_conv_req", 32'(conv_req), 32'd0);
        chk("rst_conv_word", 32'(conv_word), 32'h0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_smp_vld", 32'(smp_vld), 32'd0);
        chk("rst_ovr", 32'(ovr), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        en = 1'b1;

        // Two dummy frames
        for (int d = 0; d < 2; d++) begin
            serve(30, 1'b0, w, rc);
            chk("dummy_word", 32'(w), 32'hFFFF);
            chk("dummy_no_smp", 32'(smp_vld), 32'd0);
        end

        // Table-driven scan steps
        prev_rc = 0;
        for (int i = 0; i < 8; i++) begin
            ch_mask = vt[i].mask;
            cfg_range = vt[i].rng;
            cfg_coding = vt[i].cod;
            serve(30, vt[i].corrupt, w, rc);
            chk($sformatf("v%0d_word", i), 32'(w), 32'(vt[i].word));
            chk($sformatf("v%0d_smp_vld", i), 32'(smp_vld), 32'(vt[i].vld));
            chk($sformatf("v%0d_smp_ch", i), 32'(smp_ch), 32'(vt[i].ch));
            chk($sformatf("v%0d_smp_data", i), 32'(smp_data), 32'(vt[i].data));
            chk($sformatf("v%0d_addr_err", i), 32'(addr_err), 32'(vt[i].aerr));
            chk($sformatf("v%0d_ovr", i), 32'(ovr), 32'd0);
            if (i > 0) chk($sformatf("v%0d_spacing", i), 32'(rc - prev_rc), 32'd40);
            prev_rc = rc;
        end
        cfg_range = 1'b0;
        cfg_coding = 1'b0;

        // Slow frame overruns the next tick; ovr is sticky until err_clr
        serve(60, 1'b0, w, rc);
        chk("ovr_set", 32'(ovr), 32'd1);
        serve(30, 1'b0, w, rc);
        chk("ovr_sticky", 32'(ovr), 32'd1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("ovr_cleared", 32'(ovr), 32'd0);
        chk("addr_err_cleared", 32'(addr_err), 32'd0);

        // Period below minimum is clamped
        period = 16'd5;
        serve(30, 1'b0, w, prev_rc);
        serve(30, 1'b0, w, rc);
        chk("clamp_spacing", 32'(rc - prev_rc), 32'd40);

        // Empty mask: no requests
        ch_mask = 8'h00;
        nreq = 0;
        for (t = 0; t < 500; t++) begin
            @(negedge clk);
            if (conv_req === 1'b1) nreq++;
        end
        chk("mask0_no_req", 32'(nreq), 32'd0);
        chk("mask0_busy", 32'(busy), 32'd1);
        en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);

        // Re-entry: first result discarded, no dummy replay
        ch_mask = 8'h08;
        period = 16'd40;
        en = 1'b1;
        serve(30, 1'b0, w, rc);
        chk("reent_word", 32'(w), 32'h8F00);
        chk("reent_discard", 32'(smp_vld), 32'd0);
        chk("reent_no_aerr", 32'(addr_err), 32'd0);
        serve(30, 1'b0, w, rc);
        chk("reent2_word", 32'(w), 32'h8F00);
        chk("reent2_smp_vld", 32'(smp_vld), 32'd1);
        chk("reent2_smp_ch", 32'(smp_ch), 32'd3);
        chk("reent2_smp_data", 32'(smp_data), 32'h5A3);

        // Asynchronous reset in WAIT_DONE
        t = 0;
        while (conv_req !== 1'b1 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("pre_rst_req_seen", 32'(conv_req), 32'd1);
        conv_ack = 1'b1;
        @(negedge clk);
        conv_ack = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_conv_req", 32'(conv_req), 32'd0);
        chk("arst_conv_word", 32'(conv_word), 32'h0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_smp_ch", 32'(smp_ch), 32'd0);
        chk("arst_smp_data", 32'(smp_data), 32'd0);
        chk("arst_ovr_aerr", 32'({ovr, addr_err, smp_vld}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            serve(30, 1'b0, w, rc);
            chk("replay_dummy_word", 32'(w), 32'hFFFF);
        end
        serve(30, 1'b0, w, rc);
        chk("replay_first_word", 32'(w), 32'h8F00);
        chk("replay_first_discard", 32'(smp_vld), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
        $finish;
    end

endmodule
